// File: rtl/rover_motor_arbiter.sv
// Motor-driver pin owner shared by manual and autonomous sources.
// Manual priority with timeout, FWD interlock, dead-time and duty ramp.
module rover_motor_arbiter #(
  parameter logic [7:0]  PWM_MAX     = 8'd200,
  parameter logic [7:0]  MIN_DUTY    = 8'd100,
  parameter logic [7:0]  RAMP_STEP   = 8'd5,
  parameter logic [15:0] RAMP_DIV    = 16'd50_000,
  parameter logic [15:0] DEAD_TIME   = 16'd50_000,
  parameter logic [27:0] MAN_TIMEOUT = 28'd25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       man_valid,
  input  logic [2:0] man_dir,
  input  logic [7:0] man_duty,
  input  logic [2:0] auto_dir,
  input  logic [7:0] auto_duty,
  input  logic       object_detected,
  output logic       ENA,
  output logic       ENB,
  output logic       IN1,
  output logic       IN2,
  output logic       IN3,
  output logic       IN4,
  output logic       grant_manual,
  output logic       grant_auto,
  output logic [1:0] motor_state,
  output logic [7:0] duty_now
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_DEAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic [2:0] D_STOP = 3'd0;
  localparam logic [2:0] D_FWD  = 3'd1;
  localparam logic [3:0] PINS_OFF = 4'hF;

  function automatic logic [3:0] dir_pins(input logic [2:0] d);
    logic [3:0] p;
    p = PINS_OFF;
    unique case (1'b1)
      d == 3'd1: p = 4'b0101;
      d == 3'd2: p = 4'b1010;
      d == 3'd3: p = 4'b0110;
      d == 3'd4: p = 4'b1001;
      default:   p = PINS_OFF;
    endcase
    return p;
  endfunction

  state_e      st_q, st_d;
  logic        gman_q, gman_d;
  logic [27:0] tmr_q, tmr_d;
  logic [2:0]  mdir_q, mdir_d;
  logic [7:0]  mduty_q, mduty_d;
  logic [2:0]  dir_q, dir_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] dead_q, dead_d;
  logic [15:0] ramp_q, ramp_d;
  logic [7:0]  pwm_q, pwm_d;
  logic [3:0]  in_q, in_d;
  logic        en_q, en_d;

  logic [2:0]  src_dir, tgt_dir;
  logic [7:0]  src_duty, tgt_duty;
  logic [8:0]  d9, t9, s9, ramp9;

  always_comb begin
    src_dir  = gman_q ? mdir_q  : auto_dir;
    src_duty = gman_q ? mduty_q : auto_duty;
    tgt_dir  = (src_dir > 3'd4) ? D_STOP : src_dir;
    if (object_detected && tgt_dir == D_FWD)
      tgt_dir = D_STOP;
    tgt_duty = src_duty;
    if (src_duty < MIN_DUTY)
      tgt_duty = MIN_DUTY;
    else if (src_duty > PWM_MAX)
      tgt_duty = PWM_MAX;
  end

  // 9-bit step math so no intermediate can wrap
  always_comb begin
    d9 = {1'b0, duty_q};
    t9 = {1'b0, tgt_duty};
    s9 = {1'b0, RAMP_STEP};
    if (t9 > d9)
      ramp9 = (t9 - d9 > s9) ? d9 + s9 : t9;
    else
      ramp9 = (d9 - t9 > s9) ? d9 - s9 : t9;
  end

  always_comb begin
    gman_d  = gman_q;
    tmr_d   = tmr_q;
    mdir_d  = mdir_q;
    mduty_d = mduty_q;
    if (man_valid) begin
      gman_d  = 1'b1;
      tmr_d   = MAN_TIMEOUT;
      mdir_d  = man_dir;
      mduty_d = man_duty;
    end else if (gman_q) begin
      if (tmr_q <= 28'd1) begin
        tmr_d  = '0;
        gman_d = 1'b0;
      end else begin
        tmr_d = tmr_q - 28'd1;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    dir_d  = dir_q;
    duty_d = duty_q;
    dead_d = dead_q;
    ramp_d = ramp_q;
    in_d   = in_q;
    case (st_q)
      ST_STOP: begin
        in_d = PINS_OFF;
        if (tgt_dir != D_STOP) begin
          st_d   = ST_RUN;
          dir_d  = tgt_dir;
          duty_d = MIN_DUTY;
          ramp_d = '0;
          in_d   = dir_pins(tgt_dir);
        end
      end
      ST_RUN: begin
        if (tgt_dir != dir_q) begin
          st_d   = ST_DEAD;
          in_d   = PINS_OFF;
          duty_d = '0;
          dead_d = '0;
        end else begin
          in_d = dir_pins(dir_q);
          if (ramp_q >= RAMP_DIV - 16'd1) begin
            ramp_d = '0;
            duty_d = ramp9[7:0];
          end else begin
            ramp_d = ramp_q + 16'd1;
          end
        end
      end
      ST_DEAD: begin
        in_d = PINS_OFF;
        if (dead_q >= DEAD_TIME - 16'd1) begin
          if (tgt_dir == D_STOP) begin
            st_d = ST_STOP;
          end else begin
            st_d   = ST_RUN;
            dir_d  = tgt_dir;
            duty_d = MIN_DUTY;
            ramp_d = '0;
            in_d   = dir_pins(tgt_dir);
          end
        end else begin
          dead_d = dead_q + 16'd1;
        end
      end
      default: begin
        st_d = ST_STOP;
        in_d = PINS_OFF;
      end
    endcase
  end

  always_comb begin
    pwm_d = (pwm_q >= PWM_MAX - 8'd1) ? 8'd0 : pwm_q + 8'd1;
    en_d  = ~((st_d == ST_RUN) && (pwm_d < duty_d));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_STOP;
      gman_q  <= 1'b0;
      tmr_q   <= '0;
      mdir_q  <= '0;
      mduty_q <= '0;
      dir_q   <= '0;
      duty_q  <= '0;
      dead_q  <= '0;
      ramp_q  <= '0;
      pwm_q   <= '0;
      in_q    <= PINS_OFF;
      en_q    <= 1'b1;
    end else begin
      st_q    <= st_d;
      gman_q  <= gman_d;
      tmr_q   <= tmr_d;
      mdir_q  <= mdir_d;
      mduty_q <= mduty_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      ramp_q  <= ramp_d;
      pwm_q   <= pwm_d;
      in_q    <= in_d;
      en_q    <= en_d;
    end
  end

  assign ENA          = en_q;
  assign ENB          = en_q;
  assign {IN1, IN2, IN3, IN4} = in_q;
  assign grant_manual = gman_q;
  assign grant_auto   = ~gman_q;
  assign motor_state  = st_q;
  assign duty_now     = duty_q;

endmodule

// File: tb/tb_rover_motor_arbiter.sv
// Bench for rover_motor_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_rover_motor_arbiter;

  localparam int PMAX = 10;
  localparam int MIN  = 4;
  localparam int STEP = 2;
  localparam int RDIV = 2;
  localparam int DT   = 4;
  localparam int TMO  = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       man_valid = 1'b0;
  logic [2:0] man_dir = '0;
  logic [7:0] man_duty = '0;
  logic [2:0] auto_dir = '0;
  logic [7:0] auto_duty = '0;
  logic       object_detected = 1'b0;
  logic       ENA, ENB, IN1, IN2, IN3, IN4;
  logic       grant_manual, grant_auto;
  logic [1:0] motor_state;
  logic [7:0] duty_now;

  int n_cmp = 0;
  int n_bad = 0;

  rover_motor_arbiter #(
    .PWM_MAX(8'd10), .MIN_DUTY(8'd4), .RAMP_STEP(8'd2),
    .RAMP_DIV(16'd2), .DEAD_TIME(16'd4), .MAN_TIMEOUT(28'd20)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .man_valid(man_valid), .man_dir(man_dir), .man_duty(man_duty),
    .auto_dir(auto_dir), .auto_duty(auto_duty),
    .object_detected(object_detected),
    .ENA(ENA), .ENB(ENB), .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4),
    .grant_manual(grant_manual), .grant_auto(grant_auto),
    .motor_state(motor_state), .duty_now(duty_now)
  );

  always #5 clock = ~clock;

  logic [17:0] dut_vec;
  logic [3:0]  pins;
  assign pins = {IN1, IN2, IN3, IN4};
  assign dut_vec = {ENA, ENB, pins, grant_manual, grant_auto,
                    motor_state, duty_now};

  // st: 0 stopped, 1 dead, 2 run; dead counts clocks left
  typedef struct {
    int st; int dir; int duty; int dead; int age;
    int pwm; int tmr; bit gm; int mdir; int mduty;
  } model_t;

  model_t m = '{default: 0};

  function automatic logic [3:0] dir_code(input int d);
    case (d)
      1: return 4'b0101;
      2: return 4'b1010;
      3: return 4'b0110;
      4: return 4'b1001;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic model_t model_next(
    input model_t s, input logic mv, input int md, input int mdu,
    input int ad, input int adu, input logic ob);
    model_t n = s;
    int sd, sy, td, ty, gap;
    sd = s.gm ? s.mdir : ad;
    sy = s.gm ? s.mduty : adu;
    td = (sd > 4) ? 0 : sd;
    if (td == 1 && ob) td = 0;
    ty = (sy < MIN) ? MIN : (sy > PMAX) ? PMAX : sy;
    case (s.st)
      0: if (td != 0) begin
        n.st = 2; n.dir = td; n.duty = MIN; n.age = 0;
      end
      2: if (td != s.dir) begin
        n.st = 1; n.duty = 0; n.dead = DT;
      end else begin
        n.age = s.age + 1;
        if (n.age % RDIV == 0) begin
          gap = (ty > s.duty) ? ty - s.duty : s.duty - ty;
          if (gap > STEP) gap = STEP;
          n.duty = (ty > s.duty) ? s.duty + gap : s.duty - gap;
        end
      end
      default: begin
        n.dead = s.dead - 1;
        if (n.dead == 0) begin
          if (td == 0) n.st = 0;
          else begin
            n.st = 2; n.dir = td; n.duty = MIN; n.age = 0;
          end
        end
      end
    endcase
    if (mv) begin
      n.gm = 1'b1; n.tmr = TMO; n.mdir = md; n.mduty = mdu;
    end else if (s.gm) begin
      n.tmr = s.tmr - 1;
      if (n.tmr <= 0) begin n.tmr = 0; n.gm = 1'b0; end
    end
    n.pwm = (s.pwm + 1) % PMAX;
    return n;
  endfunction

  function automatic logic [17:0] exp_vec(input model_t s);
    logic en;
    logic [3:0] p;
    logic [1:0] st2;
    logic [7:0] d8;
    en  = !(s.st == 2 && s.pwm < s.duty);
    p   = (s.st == 2) ? dir_code(s.dir) : 4'b1111;
    st2 = s.st[1:0];
    d8  = s.duty[7:0];
    return {en, en, p, s.gm, ~s.gm, st2, d8};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      m <= '{default: 0};
    else
      m <= model_next(m, man_valid, int'(man_dir), int'(man_duty),
                      int'(auto_dir), int'(auto_duty), object_detected);
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (dut_vec !== 18'b11_1111_01_00_00000000) begin
      n_bad++;
      $display("FAIL reset_vals got=%b want=%b", dut_vec,
               18'b11_1111_01_00_00000000);
    end
    n_cmp++;
    if (dut_vec !== exp_vec(m)) begin
      n_bad++;
      $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec(m));
    end
  endtask

  task automatic test_ramp_fwd();
    int want [6] = '{4, 6, 6, 8, 8, 10};
    int lows = 0;
    auto_dir = 3'd1; auto_duty = 8'd10;
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (motor_state !== 2'b10 || pins !== 4'b0101 || duty_now !== 8'd4
        || grant_auto !== 1'b1) begin
      n_bad++;
      $display("FAIL run_entry got st=%b in=%b duty=%0d ga=%b want 10/0101/4/1",
               motor_state, pins, duty_now, grant_auto);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_cmp++;
      if (duty_now !== 8'(want[k]) || dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL ramp_step%0d got duty=%0d vec=%h want duty=%0d vec=%h",
                 k, duty_now, dut_vec, want[k], exp_vec(m));
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (ENA === 1'b0 && ENB === 1'b0) lows++;
    end
    n_cmp++;
    if (lows != 10) begin
      n_bad++;
      $display("FAIL full_duty_en got=%0d want=10", lows);
    end
  endtask

  task automatic test_dead_rev();
    int dead = 0;
    bit left = 0;
    auto_dir = 3'd2;
    for (int k = 0; k < 20 && !left; k++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL dead_model got=%h want=%h", dut_vec, exp_vec(m));
      end
      if (motor_state == 2'b01) begin
        dead++;
        n_cmp++;
        if (pins !== 4'b1111 || ENA !== 1'b1) begin
          n_bad++;
          $display("FAIL dead_pins got in=%b en=%b want 1111/1", pins, ENA);
        end
      end else if (dead > 0) begin
        left = 1;
      end
    end
    n_cmp++;
    if (dead != DT || pins !== 4'b1010 || duty_now !== 8'd4) begin
      n_bad++;
      $display("FAIL dead_len got=%0d in=%b duty=%0d want=%0d 1010 4",
               dead, pins, duty_now, DT);
    end
  endtask

  task automatic test_manual();
    int held = 0;
    bit saw_left = 0;
    auto_dir = 3'd1;
    repeat (12) @(negedge clock);
    man_valid = 1'b1; man_dir = 3'd3; man_duty = 8'd6;
    @(negedge clock);
    man_valid = 1'b0;
    n_cmp++;
    if (grant_manual !== 1'b1 || grant_auto !== 1'b0) begin
      n_bad++;
      $display("FAIL man_grant got gm=%b ga=%b want 1/0",
               grant_manual, grant_auto);
    end
    held = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (grant_manual === 1'b1) held++;
      if (motor_state == 2'b10 && pins == 4'b0110) saw_left = 1;
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL man_model got=%h want=%h", dut_vec, exp_vec(m));
      end
    end
    n_cmp++;
    if (held != TMO || !saw_left || pins !== 4'b0101) begin
      n_bad++;
      $display("FAIL man_timeout got held=%0d left=%0d in=%b want %0d 1 0101",
               held, saw_left, pins, TMO);
    end
  endtask

  task automatic test_expiry();
    int dead = 0;
    man_valid = 1'b1; man_dir = 3'd3; man_duty = 8'd6;
    @(negedge clock);
    man_valid = 1'b0;
    for (int k = 1; k < TMO; k++) @(negedge clock);
    man_valid = 1'b1;
    @(negedge clock);
    man_valid = 1'b0;
    n_cmp++;
    if (grant_manual !== 1'b1 || motor_state !== 2'b10 || pins !== 4'b0110)
    begin
      n_bad++;
      $display("FAIL expiry_keep got gm=%b st=%b in=%b want 1 10 0110",
               grant_manual, motor_state, pins);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (motor_state == 2'b01) dead++;
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL expiry_model got=%h want=%h", dut_vec, exp_vec(m));
      end
    end
    n_cmp++;
    if (dead != 0) begin
      n_bad++;
      $display("FAIL expiry_nodead got=%0d want=0", dead);
    end
  endtask

  task automatic test_obstacle();
    bit stopped = 0;
    auto_dir = 3'd1;
    repeat (30) @(negedge clock);
    object_detected = 1'b1;
    for (int k = 0; k < 20 && !stopped; k++) begin
      @(negedge clock);
      if (motor_state == 2'b00) stopped = 1;
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL obst_model got=%h want=%h", dut_vec, exp_vec(m));
      end
    end
    n_cmp++;
    if (!stopped || pins !== 4'b1111 || ENA !== 1'b1) begin
      n_bad++;
      $display("FAIL obst_stop got st=%b in=%b en=%b want 00 1111 1",
               motor_state, pins, ENA);
    end
    auto_dir = 3'd4;
    @(negedge clock);
    n_cmp++;
    if (motor_state !== 2'b10 || pins !== 4'b1001) begin
      n_bad++;
      $display("FAIL obst_right got st=%b in=%b want 10 1001",
               motor_state, pins);
    end
  endtask

  task automatic test_async_reset();
    bit stopped = 0;
    @(posedge clock); #2 reset_n = 1'b0; #1;
    n_cmp++;
    if (dut_vec !== 18'b11_1111_01_00_00000000) begin
      n_bad++;
      $display("FAIL areset_run got=%b", dut_vec);
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); auto_dir = 3'd2;
    @(negedge clock);
    n_cmp++;
    if (motor_state !== 2'b01) begin
      n_bad++;
      $display("FAIL areset_setup got st=%b want 01", motor_state);
    end
    @(posedge clock); #2 reset_n = 1'b0; #1;
    n_cmp++;
    if (dut_vec !== 18'b11_1111_01_00_00000000) begin
      n_bad++;
      $display("FAIL areset_dead got=%b", dut_vec);
    end
    @(negedge clock);
    auto_dir = 3'd1; auto_duty = 8'd2; object_detected = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL clamp_model got=%h want=%h", dut_vec, exp_vec(m));
      end
    end
    n_cmp++;
    if (duty_now !== 8'd4 || motor_state !== 2'b10) begin
      n_bad++;
      $display("FAIL clamp_min got duty=%0d st=%b want 4 10",
               duty_now, motor_state);
    end
    man_valid = 1'b1; man_dir = 3'd6; man_duty = 8'd50;
    @(negedge clock);
    man_valid = 1'b0;
    for (int k = 0; k < 20 && !stopped; k++) begin
      @(negedge clock);
      if (motor_state == 2'b00) stopped = 1;
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL dir6_model got=%h want=%h", dut_vec, exp_vec(m));
      end
    end
    n_cmp++;
    if (!stopped || pins !== 4'b1111 || grant_manual !== 1'b1) begin
      n_bad++;
      $display("FAIL dir6_stop got st=%b in=%b gm=%b want 00 1111 1",
               motor_state, pins, grant_manual);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec !== exp_vec(m)) begin
        n_bad++;
        $display("FAIL rand_model cyc=%0d got=%h want=%h",
                 k, dut_vec, exp_vec(m));
      end
      if ($urandom_range(0, 7) == 0) auto_dir = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) auto_duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) object_detected = ~object_detected;
      man_valid = ($urandom_range(0, 15) == 0);
      if (man_valid) begin
        man_dir  = 3'($urandom_range(0, 7));
        man_duty = 8'($urandom_range(0, 255));
      end
    end
    man_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_fwd();
    test_dead_rev();
    test_manual();
    test_expiry();
    test_obstacle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rover_motor_arbiter.md
Name: rover_motor_arbiter

Overview:
- Owns the L298-style motor driver pins (ENA/ENB PWM, IN1..IN4, all active-low) and shares them between two command sources.
- Sources: manual (remote/UART decoder) and autonomous (obstacle-avoidance FSM).
- Enforces manual priority with a timeout, an obstacle interlock on forward motion, a dead-time on every direction change, and a duty-cycle slew ramp.
- Sits between the command sources and the top-level motor pins, replacing direct PWM/IN drive in the sources.

Parameters:
- PWM_MAX, 8'd200: PWM period in clocks; counter runs 0..PWM_MAX-1.
- MIN_DUTY, 8'd100: minimum running duty; ramp start value.
- RAMP_STEP, 8'd5: maximum duty change per ramp tick.
- RAMP_DIV, 16'd50_000: clocks per ramp tick (1 ms at 50 MHz).
- DEAD_TIME, 16'd50_000: clocks with bridge fully off between directions.
- MAN_TIMEOUT, 28'd25_000_000: clocks without man_valid before manual loses ownership (0.5 s).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- man_valid  in  1  manual command present; level, sampled every clock.
- man_dir  in  3  manual direction code.
- man_duty  in  8  manual duty request.
- auto_dir  in  3  autonomous direction code, live level.
- auto_duty  in  8  autonomous duty request, live level.
- object_detected  in  1  obstacle ahead; blocks FWD from either source.
- ENA, ENB  out  1  active-low PWM enables.
- IN1, IN2, IN3, IN4  out  1  active-low bridge inputs.
- grant_manual  out  1  manual source owns the motors.
- grant_auto  out  1  autonomous source owns the motors.
- motor_state  out  2  00 STOPPED, 01 DEAD, 10 RUN.
- duty_now  out  8  current ramped duty.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: ENA=ENB=1; IN1..IN4=1; grant_manual=0; grant_auto=1; motor_state=STOPPED; duty_now=0.
  - Internal: manual timer=0; PWM counter=0; dead counter=0; ramp counter=0.
- Reset mid-operation forces this state immediately, with no dead-time sequencing.
- Direction codes:
  - 0 STOP: IN=1111.
  - 1 FWD: IN1..4=0,1,0,1.
  - 2 REV: 1,0,1,0.
  - 3 LEFT: 0,1,1,0.
  - 4 RIGHT: 1,0,0,1.
  - 5..7: treated as STOP.
- Ownership:
  - A clock with man_valid=1 latches man_dir/man_duty, sets grant_manual=1, grant_auto=0, and reloads the timer to MAN_TIMEOUT.
  - Otherwise, while grant_manual=1, the timer decrements; the edge where it reaches 0 sets grant_manual=0, grant_auto=1.
  - man_valid in the expiry cycle wins: the timer reloads and manual is kept.
  - grant_manual and grant_auto are always complementary.
- Target:
  - Source is the latched manual command if grant_manual, else auto_dir/auto_duty.
  - If object_detected=1 and the source dir is FWD, the target dir is STOP. REV/LEFT/RIGHT are unaffected.
  - The target duty is clamped to [MIN_DUTY, PWM_MAX].
- FSM (state and outputs update on the same edge; outputs registered):
  - STOPPED: IN=1111, EN=1. A target != STOP moves to RUN with cur_dir=target and duty_now=MIN_DUTY.
  - RUN: IN per cur_dir.
    - Target == cur_dir: stay; ramp duty.
    - Target != cur_dir (including STOP): go to DEAD; IN=1111, EN=1, duty_now=0, dead counter=0.
  - DEAD: lasts exactly DEAD_TIME clocks; the exit edge is when the counter == DEAD_TIME-1.
    - Target changes during DEAD do not restart the counter.
    - The target sampled on the exit edge decides the next state: STOP goes to STOPPED; otherwise RUN with cur_dir=target and duty_now=MIN_DUTY.
- Ramp (RUN only):
  - The ramp counter wraps every RAMP_DIV clocks.
  - On wrap, duty_now moves toward the target duty by min(RAMP_STEP, |diff|), with no overshoot.
  - Arithmetic uses 9-bit intermediates; no 8-bit wrap.
- PWM:
  - Free-running counter, 0..PWM_MAX-1 then 0.
  - ENA=ENB = 0 iff state==RUN and pwm_counter < duty_now; else 1.
  - duty_now==PWM_MAX gives EN held low continuously.

Test Plan:
(Bench parameters: PWM_MAX=10, MIN_DUTY=4, RAMP_STEP=2, RAMP_DIV=2, DEAD_TIME=4, MAN_TIMEOUT=20.)
- Reset release, auto_dir=1, auto_duty=10 -> next edge RUN, IN=0101, duty_now 4,6,8,10 every 2 clocks; ENA low 10/10 once at 10; grant_auto=1.
- In RUN FWD, auto_dir->2 -> next edge DEAD, IN=1111, ENA=1, for exactly 4 clocks; then RUN with IN=1010 and duty_now=4.
- Pulse man_valid one clock with man_dir=3, man_duty=6 while auto FWD -> grant_manual=1; DEAD then LEFT (IN=0110); after 20 clocks with no man_valid, grant_auto=1 and DEAD then FWD.
- man_valid reasserted on the exact expiry clock -> grant_manual stays 1; no DEAD entered.
- object_detected=1 during FWD -> DEAD then STOPPED (IN=1111); with auto_dir=4 and object_detected held, RUN RIGHT (IN=1001).
- reset_n low mid-RUN and mid-DEAD -> all outputs at reset values asynchronously, before the next clock edge; auto_duty=2 -> duty clamps to 4; man_dir=6 -> STOP.
